// File: rtl/rv_regfile_sb.sv
// rv_regfile_sb: integer register file with a long-latency write scoreboard.
//
// NRD combinational read ports with write-first bypass (port A over port B
// over storage), two write ports, and a per-register pending bit that decode
// uses to stall on RAW hazards against outstanding long-latency results.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   rd_addr / rd_data        packed read addresses / data, port i at [i*W +: W]
//   rd_busy                  port i's register has an outstanding port-B write
//   wa_en/wa_addr/wa_data    write port A (in-order ALU writeback)
//   wb_en/wb_addr/wb_data    write port B (long-latency writeback, clears pending)
//   mark_en/mark_addr        set pending bit at long-latency issue
//   flush                    clear every pending bit
//   pend_cnt                 number of registers currently pending
module rv_regfile_sb #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = $clog2(NREG),
    parameter int unsigned NRD  = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NRD*AW-1:0]     rd_addr,
    output logic [NRD*XLEN-1:0]   rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic                  wa_en,
    input  logic [AW-1:0]         wa_addr,
    input  logic [XLEN-1:0]       wa_data,
    input  logic                  wb_en,
    input  logic [AW-1:0]         wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic                  mark_en,
    input  logic [AW-1:0]         mark_addr,
    input  logic                  flush,
    output logic [$clog2(NREG):0] pend_cnt
);

    localparam int unsigned CW = $clog2(NREG) + 1;

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] pend_q, pend_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Qualified requests: address 0 is inert, and nothing written while in
    // reset may leak through the bypass or into state.
    logic wa_act, wb_act, mark_act;
    assign wa_act   = wa_en   & rst_n & (wa_addr   != '0);
    assign wb_act   = wb_en   & rst_n & (wb_addr   != '0);
    assign mark_act = mark_en & rst_n & (mark_addr != '0);

    // Storage; entry 0 is never written so it stays at its reset value of 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NREG; k++) begin
                regs_q[k] <= '0;
            end
        end else begin
            for (int k = 1; k < NREG; k++) begin
                if (wa_act && (wa_addr == AW'(k))) begin
                    regs_q[k] <= wa_data;
                end else if (wb_act && (wb_addr == AW'(k))) begin
                    regs_q[k] <= wb_data;
                end
            end
        end
    end

    // Pending bits: flush > mark > port-B clear > hold.
    always_comb begin
        pend_d = pend_q;
        if (flush) begin
            pend_d = '0;
        end else begin
            if (wb_act) begin
                pend_d[wb_addr] = 1'b0;
            end
            if (mark_act) begin
                pend_d[mark_addr] = 1'b1;
            end
        end
        pend_d[0] = 1'b0;
    end

    // Up/down population counter tracking pend_q without a wide adder tree.
    logic cnt_inc, cnt_dec;
    assign cnt_inc = mark_act & ~pend_q[mark_addr];
    // A same-cycle mark of the same register keeps it pending.
    assign cnt_dec = wb_act & pend_q[wb_addr] & ~(mark_act & (mark_addr == wb_addr));

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(cnt_inc) - CW'(cnt_dec);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_q <= '0;
            cnt_q  <= '0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
        end
    end

    assign pend_cnt = cnt_q;

    // Read ports: write-first bypass, port A before port B before storage.
    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   a;
        logic [XLEN-1:0] d;

        assign a = rd_addr[i*AW +: AW];

        always_comb begin
            d = regs_q[a];
            if (!rst_n || (a == '0)) begin
                d = '0;
            end else if (wa_act && (wa_addr == a)) begin
                d = wa_data;
            end else if (wb_act && (wb_addr == a)) begin
                d = wb_data;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = d;
        // The wb-bypass term is masked in a flush cycle; pend_q[0] is always 0.
        assign rd_busy[i] = pend_q[a] & ~(wb_act & (wb_addr == a) & ~flush);
    end

endmodule

// File: doc/rv_regfile_sb.md
# rv_regfile_sb

Parametrised integer register file with scoreboard for the pipelined core. It provides NRD combinational read ports with write-first bypass and two write ports. Port A carries in-order ALU writeback; port B carries long-latency writeback such as loads or multiply/divide. A per-register pending bit, set at issue and cleared at port-B writeback, lets decode stall on RAW hazards. The block sits between decode/issue and the writeback stage and replaces the single-write-port register file.

## Interface
- XLEN, 32, data width of each register.
- NREG, 32, number of architectural registers; power of two, 2..64.
- AW, $clog2(NREG), register address width.
- NRD, 2, number of read ports, 1..4.
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rd_addr  in  NRD*AW  read addresses; port i occupies bits [i*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port i occupies bits [i*XLEN +: XLEN].
- rd_busy  out  NRD  port i's register has an outstanding long-latency write.
- wa_en / wa_addr / wa_data  in  1 / AW / XLEN  write port A (ALU writeback).
- wb_en / wb_addr / wb_data  in  1 / AW / XLEN  write port B (long-latency writeback); also clears the pending bit.
- mark_en / mark_addr  in  1 / AW  sets the pending bit for mark_addr (long-latency issue).
- flush  in  1  clears all pending bits (pipeline redirect).
- pend_cnt  out  $clog2(NREG)+1  number of registers currently pending.

## Operation
- Register 0 is hardwired to zero. Writes and marks to address 0 are ignored. Reads of address 0 return 0 with rd_busy=0.
- Write, address k != 0:
  - The write commits at the clock edge.
  - If both ports are enabled for the same k, port A's data is stored.
  - Different addresses on the two ports write in the same cycle independently.
- Read port i, combinational, address k != 0. The first match wins:
  - wa_en & wa_addr==k gives wa_data.
  - wb_en & wb_addr==k gives wb_data.
  - Otherwise the stored value.
- Scoreboard, per register k, next value of pending[k]:
  - flush gives 0 for all k. It overrides mark and wb in that cycle.
  - Else mark_en & mark_addr==k gives 1. Mark wins over a same-cycle port-B clear of the same k.
  - Else wb_en & wb_addr==k gives 0.
  - Else pending[k] holds.
- Port A never changes pending bits.
- rd_busy[i] = pending[rd_addr_i] & ~(wb_en & wb_addr==rd_addr_i & ~flush). The register being written back this cycle reads as not busy, and its data is bypassed.
- pend_cnt:
  - It always equals the population count of the pending bits, maintained as an up/down counter: +1 on a set of a clear bit, -1 on a clear of a set bit, net 0 when both occur.
  - flush loads 0.
  - Marking an already-pending register does not increment.
  - A port-B write to a non-pending register does not decrement.
- Rule for the implementation: read and busy paths are purely combinational. Each rd_data bit is a mux of at most 3 sources after address decode.

## Timing
- Reset, asynchronous: all registers = 0, all pending = 0, pend_cnt = 0. rd_data therefore reads 0 and rd_busy reads 0 from reset assertion onward.
- Deassertion of rst_n is synchronised externally. The first write can commit on the first rising edge after release.
- Write latency is 0 cycles through the bypass. The value is visible from storage from the cycle after the edge.
- Mark latency is 1 cycle: rd_busy for that register rises in the cycle after mark_en.
- Port-B clear is visible in the same cycle (bypass) and in storage from the next cycle.
- flush affects rd_busy from the cycle after assertion. In the flush cycle itself rd_busy still reflects the old pending bits, except that the wb-bypass term is disabled.
- No handshakes: every enabled write and mark is accepted every cycle.
- Reset asserted mid-operation discards any same-cycle write, mark or flush.

## Test plan
- Reset then read:
  - rst_n low, wa_en=1, wa_addr=3, wa_data=0x1234: all rd_data=0, pend_cnt=0, rd_busy=0.
  - After release, write reg 3 = 0x1234: read reg 3 returns 0x1234 in the same cycle and after the edge.
- x0 handling: wa_en=1, wa_addr=0, wa_data=0xFFFFFFFF, plus mark_addr=0 -> reg 0 reads 0, pend_cnt stays 0, rd_busy=0.
- Dual write collision: wa and wb both target reg 5 with 0xAAAA / 0x5555 -> rd_data=0xAAAA in the same cycle and after the edge.
- Scoreboard lifecycle:
  - Mark reg 7 -> the next cycle rd_busy=1 and pend_cnt=1.
  - wb to reg 7 with 0xBEEF -> rd_busy=0 and rd_data=0xBEEF that cycle; pend_cnt=0 after the edge.
- Simultaneous mark and clear of reg 9 while pending -> stays pending, pend_cnt unchanged.
- Flush: mark regs 1, 2, 3 (pend_cnt=3), then flush with mark_en on reg 4 -> pend_cnt=0 and all rd_busy=0 the next cycle.
- Random sweep with NRD=4, NREG=16: 10k cycles against a reference model. Check rd_data, rd_busy and pend_cnt every cycle, including redundant marks and clears of non-pending registers.
